// File: rtl/ysyx_23060072_multdiv_pkg.sv
// rtl/ysyx_23060072_multdiv_pkg.sv - RV32M opcode encodings, FSM state type and helpers
// Purpose: constants shared by id_stage, ex_stage and the multiply/divide unit.
// Ports: none (package).
package ysyx_23060072_multdiv_pkg;

    localparam logic [3:0] OP_MUL    = 4'd0;
    localparam logic [3:0] OP_MULH   = 4'd1;
    localparam logic [3:0] OP_MULHSU = 4'd2;
    localparam logic [3:0] OP_MULHU  = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_DIVU   = 4'd5;
    localparam logic [3:0] OP_REM    = 4'd6;
    localparam logic [3:0] OP_REMU   = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    // Opcodes 4..7 take the divide datapath; everything else (including the
    // reserved range) runs the multiply datapath.
    function automatic logic is_div_op(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

endpackage

// File: rtl/ysyx_23060072_multdiv.sv
// rtl/ysyx_23060072_multdiv.sv - iterative RV32M multiply/divide unit
// Purpose: 32-iteration shift-add multiply and restoring divide sharing one
//          33-bit adder, with sign fix-up and a one-cycle result strobe.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   multdiv_en_i           EX-stage RV32M request
//   multdiv_opcode_i       operation select (see package)
//   operand_a_i/b_i        rs1/rs2 values
//   flush_i                pipeline flush, aborts any operation
//   multdiv_hold_flag_o    stall request to the controller
//   result_valid_o         result_o valid this cycle
//   result_o               rd write data, 0 when not valid
module ysyx_23060072_multdiv
    import ysyx_23060072_multdiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        multdiv_en_i,
    input  logic [3:0]  multdiv_opcode_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        flush_i,
    output logic        multdiv_hold_flag_o,
    output logic        result_valid_o,
    output logic [31:0] result_o
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic        sign_q, sign_d;
    logic [31:0] hi_q, hi_d;        // product high word / partial remainder
    logic [31:0] lo_q, lo_d;        // multiplier->product low word / dividend->quotient
    logic [31:0] dvs_q, dvs_d;      // multiplicand or divisor magnitude
    logic [31:0] result_q, result_d;

    logic        signed_a, signed_b, neg_a, neg_b, div_zero, div_q;
    logic [31:0] mag_a, mag_b;
    logic [32:0] add_x, add_y;
    logic [33:0] add_sum;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

    // Operand decode for a new request.
    always_comb begin
        signed_a = (multdiv_opcode_i == OP_MULH) || (multdiv_opcode_i == OP_MULHSU) ||
                   (multdiv_opcode_i == OP_DIV)  || (multdiv_opcode_i == OP_REM);
        signed_b = (multdiv_opcode_i == OP_MULH) || (multdiv_opcode_i == OP_DIV) ||
                   (multdiv_opcode_i == OP_REM);
        neg_a    = signed_a && operand_a_i[31];
        neg_b    = signed_b && operand_b_i[31];
        mag_a    = neg_a ? neg32(operand_a_i) : operand_a_i;
        mag_b    = neg_b ? neg32(operand_b_i) : operand_b_i;
        div_zero = is_div_op(multdiv_opcode_i) && (operand_b_i == 32'd0);
    end

    // Shared adder: multiply adds the multiplicand when the multiplier LSB is
    // set; divide subtracts the divisor from {rem, next dividend bit}, and the
    // carry out says whether the subtraction fits (no borrow).
    always_comb begin
        div_q   = is_div_op(op_q);
        add_x   = div_q ? {hi_q, lo_q[31]} : {1'b0, hi_q};
        add_y   = div_q ? ~{1'b0, dvs_q} : (lo_q[0] ? {1'b0, dvs_q} : 33'd0);
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {33'd0, div_q};
    end

    always_comb begin
        prod_fix = sign_q ? (~{hi_q, lo_q}) + 64'd1 : {hi_q, lo_q};
        quot_fix = sign_q ? neg32(lo_q) : lo_q;
        rem_fix  = sign_q ? neg32(hi_q) : hi_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_d   = sign_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dvs_d    = dvs_q;
        result_d = result_q;

        unique case (state_q)
            ST_IDLE: begin
                if (multdiv_en_i && !flush_i) begin
                    op_d   = multdiv_opcode_i;
                    sign_d = (multdiv_opcode_i == OP_REM) ? neg_a : (neg_a ^ neg_b);
                    hi_d   = 32'd0;
                    lo_d   = mag_a;
                    dvs_d  = mag_b;
                    cnt_d  = 5'd0;
                    if (div_zero) begin
                        result_d = multdiv_opcode_i[1] ? operand_a_i : 32'hFFFF_FFFF;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (div_q) begin
                    hi_d = add_sum[33] ? add_sum[31:0] : add_x[31:0];
                    lo_d = {lo_q[30:0], add_sum[33]};
                end else begin
                    hi_d = add_sum[32:1];
                    lo_d = {add_sum[0], lo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                case (op_q)
                    OP_MUL:                        result_d = prod_fix[31:0];
                    OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod_fix[63:32];
                    OP_DIV, OP_DIVU:               result_d = quot_fix;
                    OP_REM, OP_REMU:               result_d = rem_fix;
                    default:                       result_d = 32'd0;
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush_i) begin
            state_d  = ST_IDLE;
            cnt_d    = 5'd0;
            result_d = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 4'd0;
            sign_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            dvs_q    <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
        end
    end

    assign multdiv_hold_flag_o = !flush_i && (((state_q == ST_IDLE) && multdiv_en_i) ||
                                              (state_q == ST_CALC) || (state_q == ST_FIX));
    assign result_valid_o      = (state_q == ST_DONE);
    assign result_o            = result_valid_o ? result_q : 32'd0;

endmodule

// File: tb/tb_ysyx_23060072_multdiv.sv
// tb/tb_ysyx_23060072_multdiv.sv - directed self-checking bench for ysyx_23060072_multdiv
module tb_ysyx_23060072_multdiv;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  opcode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        hold;
    logic        valid;
    logic [31:0] result;

    int n_checks;
    int n_errors;

    ysyx_23060072_multdiv dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .multdiv_en_i        (en),
        .multdiv_opcode_i    (opcode),
        .operand_a_i         (op_a),
        .operand_b_i         (op_b),
        .flush_i             (flush),
        .multdiv_hold_flag_o (hold),
        .result_valid_o      (valid),
        .result_o            (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request in the next cycle (cycle 0), keep multdiv_en_i high
    // like a stalled EX stage, and wait for the result strobe.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        bit hold_ok;
        bit seen;
        @(posedge clk);
        #1;
        en = 1'b1; opcode = op; op_a = a; op_b = b;
        #1;
        lat = 0; hold_ok = 1'b1; seen = 1'b0;
        while (!seen && lat <= 60) begin
            if (valid) begin
                seen = 1'b1;
            end else begin
                if (!hold) hold_ok = 1'b0;
                @(posedge clk);
                #2;
                lat++;
            end
        end
        check({tag, "_valid"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({tag, "_result"}, result, exp_res);
            check({tag, "_hold_done"}, {31'd0, hold}, 32'd0);
        end
        en = 1'b0;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_hold_busy"}, {31'd0, hold_ok}, 32'd1);
    endtask

    initial begin
        int vcount;
        n_checks = 0;
        n_errors = 0;
        en = 1'b0; opcode = 4'd0; op_a = 32'd0; op_b = 32'd0; flush = 1'b0;
        rst_n = 1'b0;
        #2;
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_hold", {31'd0, hold}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op("mul_7_m3", 4'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        @(posedge clk);
        #2;
        check("after_done_valid", {31'd0, valid}, 32'd0);
        check("after_done_result", result, 32'd0);

        run_op("mulhu_m1", 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("mulh_m1", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        run_op("mulhsu_m1", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_op("mulh_min", 4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run_op("div_m7_2", 4'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem_m7_2", 4'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("div_ovf", 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        run_op("rem_ovf", 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        run_op("divu_100_7", 4'd5, 32'd100, 32'd7, 32'd14, 34);
        run_op("remu_100_7", 4'd7, 32'd100, 32'd7, 32'd2, 34);
        run_op("divu_by0", 4'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_by0", 4'd7, 32'd5, 32'd0, 32'd5, 1);
        run_op("rem_neg_by0", 4'd6, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 1);
        run_op("reserved", 4'd9, 32'd123, 32'd456, 32'd0, 34);

        // Flush in cycle 10 of a DIV.
        @(posedge clk);
        #1;
        en = 1'b1; opcode = 4'd4; op_a = 32'd100; op_b = 32'd3;
        #1;
        repeat (10) begin
            @(posedge clk);
            #2;
        end
        flush = 1'b1;
        #1;
        check("flush_hold_gated", {31'd0, hold}, 32'd0);
        @(posedge clk);
        #2;
        flush = 1'b0; en = 1'b0;
        #1;
        check("flush_idle_valid", {31'd0, valid}, 32'd0);
        check("flush_idle_hold", {31'd0, hold}, 32'd0);
        run_op("mul_after_flush", 4'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);

        // Reset in cycle 20 of a MUL.
        @(posedge clk);
        #1;
        en = 1'b1; opcode = 4'd0; op_a = 32'd3; op_b = 32'd5;
        #1;
        repeat (20) begin
            @(posedge clk);
            #2;
        end
        check("pre_reset_hold", {31'd0, hold}, 32'd1);
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset_valid", {31'd0, valid}, 32'd0);
        check("midreset_result", result, 32'd0);
        check("midreset_hold", {31'd0, hold}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        vcount = 0;
        repeat (40) begin
            @(posedge clk);
            #2;
            if (valid) vcount++;
        end
        check("no_valid_after_reset", vcount, 32'd0);
        run_op("fresh_after_reset", 4'd0, 32'd3, 32'd5, 32'd15, 34);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
